ahb_master_arbiter: RTL

- Shares one AHB-Lite master port between NUM_REQ local requesters.
- Each requester has a simple valid/accept request channel and a pulsed response channel.
- Arbitration is round-robin. Only SINGLE, NONSEQ transfers are issued.
- Address and data phases are pipelined back-to-back, and slave wait states (HREADY) and error responses (HRESP) are handled.
- Sits between the agent/sequencer-side request logic and the AHB interconnect; replaces ad-hoc per-requester master BFMs.

---
 rtl/ahb_master_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
// Shares one AHB-Lite master port between NUM_REQ local requesters using
// round-robin arbitration. It issues only SINGLE / NONSEQ transfers. Address
// and data phases are pipelined back-to-back, so one transfer can complete
// per cycle. Slave wait states (HREADY=0) and ERROR responses are honoured.
//
// Handshakes:
//   request  : the requester holds req[i] and its fields stable. The request
//              is taken at a posedge where req[i] & gnt[i]. Dropping req
//              before it is taken is allowed and issues nothing.
//   response : rsp_valid[i] pulses for exactly one cycle. It carries
//              rsp_rdata (0 for writes) and rsp_err. There is no back-pressure.
//
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   req/req_write         per-requester valid and direction
//   req_addr/wdata/size   packed per-requester fields (requester i at slice i)
//   gnt                   combinational accept, at most one bit set
//   rsp_valid/rdata/err   registered completion to the owning requester
//   H*                    AHB-Lite master signals (all registered)

module ahb_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*3-1:0]      req_size,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         HADDR,
    output logic                      HWRITE,
    output logic [1:0]                HTRANS,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [3:0]                HPROT,
    output logic                      HMASTLOCK,
    output logic [DATA_W-1:0]         HWDATA,
    input  logic                      HREADY,
    input  logic [DATA_W-1:0]         HRDATA,
    input  logic                      HRESP
);

    localparam int         IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_NSEQ = 2'b10;

    logic [IDX_W-1:0]  last_granted;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic              take;
    int                idx;

    // Address-phase slot: owner and write data waiting for the data phase.
    logic [IDX_W-1:0]  ap_owner;
    logic [DATA_W-1:0] ap_wdata;

    // Data-phase slot: the transfer whose completion is being waited on.
    logic              dp_valid;
    logic              dp_write;
    logic [IDX_W-1:0]  dp_owner;

    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    // Round-robin scan: start one past the last winner and take the first
    // active request.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_granted) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    // A grant only fires while the bus can advance, which is when HREADY=1.
    assign take = found & HREADY & ~HRESET;

    always_comb begin
        gnt = '0;
        if (take) begin
            gnt[winner] = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HTRANS       <= TRANS_IDLE;
            HADDR        <= '0;
            HWRITE       <= 1'b0;
            HSIZE        <= 3'b000;
            HWDATA       <= '0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            ap_owner     <= '0;
            ap_wdata     <= '0;
            dp_valid     <= 1'b0;
            dp_write     <= 1'b0;
            dp_owner     <= '0;
            // The last slot counts as the previous winner, so requester 0
            // has the highest priority first.
            last_granted <= IDX_W'(NUM_REQ - 1);
        end else begin
            rsp_valid <= '0;
            if (HREADY) begin
                // Completion of the transfer currently in its data phase.
                if (dp_valid) begin
                    rsp_valid[dp_owner] <= 1'b1;
                    rsp_rdata           <= dp_write ? '0 : HRDATA;
                    rsp_err             <= HRESP;
                end

                // The address phase moves into the data phase.
                dp_valid <= (HTRANS == TRANS_NSEQ);
                dp_owner <= ap_owner;
                dp_write <= HWRITE;
                if (HTRANS == TRANS_NSEQ && HWRITE) begin
                    HWDATA <= ap_wdata;
                end

                // A new address phase starts, or the bus goes idle. The
                // control signals hold while idle.
                if (take) begin
                    HTRANS       <= TRANS_NSEQ;
                    HADDR        <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
                    HWRITE       <= req_write[winner];
                    HSIZE        <= req_size[int'(winner)*3 +: 3];
                    ap_owner     <= winner;
                    ap_wdata     <= req_wdata[int'(winner)*DATA_W +: DATA_W];
                    last_granted <= winner;
                end else begin
                    HTRANS <= TRANS_IDLE;
                end
            end
            // HREADY=0: everything holds. This includes the first cycle of a
            // two-cycle ERROR response.
        end
    end

endmodule
